rr_burst_arbiter: RTL

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/rr_burst_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Four-way round-robin arbiter that locks onto one requester for up to BURST
// beats and forwards the data through a single registered output slot.
module rr_burst_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_din_0,
  input  logic [WIDTH-1:0] io_din_1,
  input  logic [WIDTH-1:0] io_din_2,
  input  logic [WIDTH-1:0] io_din_3,
  input  logic             io_din_v_0,
  input  logic             io_din_v_1,
  input  logic             io_din_v_2,
  input  logic             io_din_v_3,
  output logic             io_din_r_0,
  output logic             io_din_r_1,
  output logic             io_din_r_2,
  output logic             io_din_r_3,
  output logic [WIDTH-1:0] io_dout,
  output logic             io_dout_v,
  input  logic             io_dout_r,
  output logic [1:0]       io_grant,
  output logic             io_busy
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [1:0]       grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_v_q, dout_v_d;

  logic [3:0]       din_v;
  logic [WIDTH-1:0] din_arr [4];
  logic             slot_free;
  logic             accept;
  logic [CW-1:0]    cnt_inc;
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [3:0]       ready_vec;

  assign din_v      = {io_din_v_3, io_din_v_2, io_din_v_1, io_din_v_0};
  assign din_arr[0] = io_din_0;
  assign din_arr[1] = io_din_1;
  assign din_arr[2] = io_din_2;
  assign din_arr[3] = io_din_3;

  // The output slot can take a new word when empty or being drained this edge
  assign slot_free = ~dout_v_q | io_dout_r;
  assign accept    = (state_q == LOCK) & din_v[grant_q] & slot_free;
  assign cnt_inc   = cnt_q + CW'(1);

  // Round-robin search starting one past the last granted channel, with wrap
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant_q + 2'd1;
    for (int k = 1; k <= 4; k++) begin
      if (!pick_valid && din_v[last_grant_q + 2'(k)]) begin
        pick_valid = 1'b1;
        pick_idx   = last_grant_q + 2'(k);
      end
    end
  end

  // Only the locked channel sees ready, and only while the slot can accept
  always_comb begin
    ready_vec = 4'b0000;
    if (state_q == LOCK && slot_free) begin
      ready_vec[grant_q] = 1'b1;
    end
  end

  assign io_din_r_0 = ready_vec[0];
  assign io_din_r_1 = ready_vec[1];
  assign io_din_r_2 = ready_vec[2];
  assign io_din_r_3 = ready_vec[3];

  // Next-state logic for the grant FSM, beat counter and output slot
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_v_d     = dout_v_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (!din_v[grant_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(BURST)) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      dout_d   = din_arr[grant_q];
      dout_v_d = 1'b1;
    end else if (dout_v_q && io_dout_r) begin
      dout_v_d = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held word
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      grant_q      <= 2'd0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_v_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_v_q     <= dout_v_d;
    end
  end

  assign io_dout   = dout_q;
  assign io_dout_v = dout_v_q;
  assign io_grant  = grant_q;
  assign io_busy   = (state_q == LOCK);

endmodule
